// File: rtl/mux_n_reg_if.sv
// Handshake bundle for mux_n_reg: the producer side offers a/ch with
// in_valid/in_ready, and the consumer side takes out/out_ch with
// out_valid/out_ready. The error flag and its clear are also carried here.
interface mux_n_reg_if #(
    parameter int WIDTH = 32,
    parameter int NUM   = 3,
    parameter int SEL_W = 2
);
    logic [NUM*WIDTH-1:0] a;
    logic [SEL_W-1:0]     ch;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out;
    logic [SEL_W-1:0]     out_ch;
    logic                 out_valid;
    logic                 out_ready;
    logic                 sel_err;
    logic                 err_clr;

    // Environment view: drives the stimulus and the consumer ready.
    modport master (
        output a, ch, in_valid, out_ready, err_clr,
        input  in_ready, out, out_ch, out_valid, sel_err
    );

    // Stage view: the selector itself.
    modport slave (
        input  a, ch, in_valid, out_ready, err_clr,
        output in_ready, out, out_ch, out_valid, sel_err
    );
endinterface

// File: rtl/mux_n_reg.sv
// N-input, WIDTH-bit selector with a one-entry registered output stage.
// Holds the selected value across consumer stalls, allows one transfer per
// cycle when the consumer keeps up, and traps out-of-range selects in a
// sticky error flag while loading DEFAULT instead.
module mux_n_reg #(
    parameter int               WIDTH   = 32,
    parameter int               NUM     = 3,
    parameter int               SEL_W   = 2,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic       clk,
    input  logic       rst,
    mux_n_reg_if.slave bus
);

    // Reject configurations that would leave inputs unreachable by ch.
    if (NUM < 2 || NUM > 16) begin : g_num_range_err
        $error("mux_n_reg: NUM=%0d outside 2..16", NUM);
    end
    if (NUM > (1 << SEL_W)) begin : g_sel_w_err
        $error("mux_n_reg: NUM=%0d needs more than SEL_W=%0d select bits", NUM, SEL_W);
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   out_q;
    logic [SEL_W-1:0]   out_ch_q;
    logic               sel_err_q;
    logic               sel_err_d;

    logic               out_valid;
    logic               in_ready;
    logic               accept;
    logic               drain;
    logic               in_range;
    logic [WIDTH-1:0]   sel_val;

    // Handshake: ready whenever the slot is empty or is being emptied now,
    // so in_ready never depends on in_valid.
    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;
    assign drain     = out_valid && bus.out_ready && !accept;

    // Both sides widened to 32 bits so no ch value can wrap onto a valid index.
    assign in_range  = (32'(bus.ch) < 32'(NUM));

    // Input selection: DEFAULT unless ch names one of the NUM inputs.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        sel_val = DEFAULT;
        for (int k = 0; k < NUM; k++) begin
            if (32'(bus.ch) == 32'(k)) begin
                sel_val = bus.a[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and sticky-error logic; a set on the same edge as a clear wins.
    always_comb begin
        state_d   = state_q;
        sel_err_d = sel_err_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (drain)  state_d = EMPTY;
            default:           state_d = EMPTY;
        endcase
        if (bus.err_clr) begin
            sel_err_d = 1'b0;
        end
        if (accept && !in_range) begin
            sel_err_d = 1'b1;
        end
    end

    // State, output register and error flag; reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (rst) begin
            state_q   <= EMPTY;
            out_q     <= '0;
            out_ch_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_err_q <= sel_err_d;
            // Data only moves on accept; a drain leaves the last value visible.
            if (accept) begin
                out_q    <= sel_val;
                out_ch_q <= bus.ch;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out       = out_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.sel_err   = sel_err_q;

endmodule
